// File: rtl/math_pkg.sv
`default_nettype none
// ============================================================================
// Module      : math_pkg
// Description : Shared 3:2 compressor primitive and accumulator state type.
// Revision    : 1.0 - initial release
// ============================================================================
package math_pkg;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } csa_acc_state_e;

    // Returns {carry, sum} for one bit position of a full adder.
    function automatic logic [1:0] compressor32(input logic a, input logic b, input logic c);
        logic w_x;
        w_x = a ^ b;
        return {(a & b) | (w_x & c), w_x ^ c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
// Module      : csa_row
// Description : Combinational DW-wide row of 3:2 compressors, carry pre-shifted.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_row
    import math_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    output logic [DW-1:0] o_sum,
    output logic [DW-1:0] o_carry
);

    assign o_carry[0] = 1'b0;

    generate
        for (genvar g = 0; g < DW; g++) begin : g_bit
            if (g < DW - 1) begin : g_body
                assign {o_carry[g+1], o_sum[g]} = compressor32(i_a[g], i_b[g], i_c[g]);
            end else begin : g_msb
                // The MSB carry falls off the modulo-2^DW word, so only its sum is built.
                assign o_sum[g] = i_a[g] ^ i_b[g] ^ i_c[g];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/csa_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : csa_acc_seq
// Description : Sequential carry-save multi-operand accumulator with iterative resolve.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_acc_seq
    import math_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_sum_o,
    output logic [CW-1:0] out_cnt_o,
    output logic          busy_o
);

    localparam logic [CW-1:0] c_CNT_MAX = '1;

    csa_acc_state_e r_state;
    logic [DW-1:0]  r_s;
    logic [DW-1:0]  r_c;
    logic [CW-1:0]  r_cnt;

    logic [DW-1:0]  w_third;
    logic [DW-1:0]  w_sum;
    logic [DW-1:0]  w_carry;

    // With the third input zeroed the row degenerates to a half-adder step.
    assign w_third = (r_state == ACC) ? in_data_i : '0;

    csa_row #(
        .DW (DW)
    ) u_row (
        .i_a     (r_s),
        .i_b     (r_c),
        .i_c     (w_third),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ACC;
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (in_valid_i) begin
                        r_s   <= w_sum;
                        r_c   <= w_carry;
                        r_cnt <= (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                        if (in_last_i) begin
                            r_state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    if (r_c == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_s <= w_sum;
                        r_c <= w_carry;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= ACC;
                    end
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == ACC);
    assign out_valid_o = (r_state == DONE);
    assign out_sum_o   = r_s;
    assign out_cnt_o   = r_cnt;
    assign busy_o      = (r_state != ACC) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_csa_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_acc_seq
// Description : Scoreboard bench for csa_acc_seq with directed jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_acc_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic        in_last_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_sum_o;
    logic [7:0]  out_cnt_o;
    logic        busy_o;

    typedef struct {
        int sum;
        int cnt;
        int lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests;
    int   fails;
    int   cyc;
    int   last_cyc;
    logic prev_valid;

    csa_acc_seq #(
        .DW (16),
        .CW (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_sum_o   (out_sum_o),
        .out_cnt_o   (out_cnt_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    initial prev_valid = 1'b0;
    always @(negedge clk_i) begin
        #1;
        if (!rst_ni) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid_i && in_ready_o && in_last_i) last_cyc = cyc;
            if (out_valid_o && !prev_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: out_valid_o=1 with sum 0x%0h, no result expected", out_sum_o);
                end else if (q[0].lat >= 0) begin
                    check("latency", cyc - last_cyc, q[0].lat);
                end
            end
            if (out_valid_o && out_ready_i && q.size() > 0) begin
                e = q.pop_front();
                check("out_sum", int'(out_sum_o), e.sum);
                check("out_cnt", int'(out_cnt_o), e.cnt);
            end
            prev_valid = out_valid_o;
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        while (!in_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready_o stayed 0, expected 1 within 100 cycles");
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!out_valid_o) begin
            tests++;
            fails++;
            $display("FAIL out_timeout: out_valid_o stayed 0, expected 1 within 100 cycles");
        end else if (out_ready_i) begin
            @(negedge clk_i);
            check("ready_after_out", int'(in_ready_o), 1);
            check("valid_single_pulse", int'(out_valid_o), 0);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        last_cyc    = 0;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_in_ready", int'(in_ready_o), 1);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_out_sum", int'(out_sum_o), 0);
        check("rst_out_cnt", int'(out_cnt_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1+2+3+4+5: redundant pair ends with c=0, so no resolve steps
        q.push_back('{sum: 16'h000F, cnt: 5, lat: 2});
        for (int i = 1; i <= 5; i++) send(i[15:0], i == 5);
        wait_out();

        // 0xFFFF + 0x0001: carry ripples 15 times before resolving to 0
        q.push_back('{sum: 16'h0000, cnt: 2, lat: 17});
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        wait_out();

        // Single-beat job
        q.push_back('{sum: 16'h1234, cnt: 1, lat: 2});
        send(16'h1234, 1'b1);
        wait_out();

        // Backpressure: result held, pending beat not consumed
        out_ready_i = 1'b0;
        q.push_back('{sum: 16'h0007, cnt: 2, lat: 2});
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b1);
        wait_out();
        in_valid_i = 1'b1;
        in_data_i  = 16'h0007;
        in_last_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("bp_in_ready", int'(in_ready_o), 0);
            check("bp_out_valid", int'(out_valid_o), 1);
            check("bp_out_sum", int'(out_sum_o), 16'h0007);
            check("bp_out_cnt", int'(out_cnt_o), 2);
        end
        q.push_back('{sum: 16'h0007, cnt: 1, lat: 2});
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_ready_next", int'(in_ready_o), 1);
        check("bp_valid_drop", int'(out_valid_o), 0);
        @(negedge clk_i);
        check("bp_beat_taken_cnt", int'(out_cnt_o), 1);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        wait_out();

        // Reset mid-job discards the partial job, asynchronously
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        check("mid_cnt", int'(out_cnt_o), 3);
        check("mid_busy", int'(busy_o), 1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_cnt", int'(out_cnt_o), 0);
        check("async_rst_sum", int'(out_sum_o), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_ready", int'(in_ready_o), 1);
        check("async_rst_valid", int'(out_valid_o), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        q.push_back('{sum: 16'h0030, cnt: 2, lat: 2});
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b1);
        wait_out();

        // Counter saturates at 255 while the sum keeps counting
        q.push_back('{sum: 300, cnt: 255, lat: -1});
        for (int i = 1; i <= 300; i++) send(16'h0001, i == 300);
        wait_out();

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
